// File: rtl/pixel_fetch_sequencer_pkg.sv
// Shared types and pixel helpers for the packed-pixel fetch sequencer.
// Narrow pixels sit LSB-first in each byte; high_bits fill the bits above them.
package pixel_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BPP_1 = 2'd0,
        BPP_2 = 2'd1,
        BPP_4 = 2'd2,
        BPP_8 = 2'd3
    } bpp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] pixels_per_byte(input logic [1:0] bpp_log2);
        return 4'd8 >> bpp_log2;
    endfunction

    function automatic logic [7:0] extract_pixel(
        input logic [1:0] bpp_log2,
        input logic [7:0] data,
        input logic [2:0] bit_off,
        input logic [7:0] high_bits,
        input logic       keep_0
    );
        logic [7:0] mask;
        logic [7:0] v;
        case (bpp_e'(bpp_log2))
            BPP_1:   mask = 8'h01;
            BPP_2:   mask = 8'h03;
            BPP_4:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        v = (data >> bit_off) & mask;
        if (keep_0 && v == 8'h00)
            return 8'h00;
        // at 8bpp ~mask is zero, so high_bits drop out naturally
        return (high_bits & ~mask) | v;
    endfunction

endpackage

// File: rtl/pixel_fetch_sequencer_byte_queue2.sv
// Two-entry byte FIFO holding fetched pixel bytes; the head is read combinationally.
module byte_queue2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [1:0] count
);

    logic [7:0] slot [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= push_data;
    end

    assign head = slot[rd_ptr];

endmodule

// File: rtl/pixel_fetch_sequencer.sv
// Fetches a run of packed pixel bytes from memory and streams them out as one
// 8-bit pixel per handshake, keeping at most two bytes queued or in flight.
module pixel_fetch_sequencer
    import pixel_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_SIZE   = 11,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_SIZE-1:0]   start_addr,
    input  logic [COUNT_WIDTH-1:0] num_pixels,
    input  logic [1:0]             bpp_log2,
    input  logic [7:0]             high_bits,
    input  logic                   keep_0,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic                   mem_enable,
    input  logic [7:0]             mem_data,
    output logic                   busy,
    output logic                   done,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [7:0]             pix_data,
    output logic                   pix_last
);

    state_e                 state, state_nxt;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [COUNT_WIDTH-1:0] bytes_left, pixels_left, bytes_calc;
    logic [COUNT_WIDTH:0]   round_up;
    logic [1:0]             bpp_q;
    logic [7:0]             high_q;
    logic                   keep0_q;
    logic [2:0]             sub_idx;
    logic                   inflight, done_q;
    logic [1:0]             q_count;
    logic [7:0]             q_head;
    logic                   accept, xfer, pop, last_pix, sub_at_end;
    logic [2:0]             credit_use;

    assign round_up   = {1'b0, num_pixels} + (COUNT_WIDTH+1)'(pixels_per_byte(bpp_log2) - 4'd1);
    assign bytes_calc = COUNT_WIDTH'(round_up >> (2'd3 - bpp_log2));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state == ST_RUN);
        accept     = start && (state == ST_IDLE);
        pix_valid  = busy && (q_count != 2'd0);
        xfer       = pix_valid && pix_ready;
        last_pix   = (pixels_left == COUNT_WIDTH'(1));
        pix_last   = pix_valid && last_pix;
        sub_at_end = ({1'b0, sub_idx} == pixels_per_byte(bpp_q) - 4'd1);
        pop        = xfer && (sub_at_end || last_pix);
        // a slot is free if what is queued or returning, minus the byte leaving now, is under 2
        credit_use = 3'(q_count) + 3'(inflight) - 3'(pop);
        mem_enable = busy && (bytes_left != '0) && (credit_use < 3'd2);
        case (state)
            ST_IDLE: if (accept && num_pixels != '0) state_nxt = ST_RUN;
            ST_RUN:  if (xfer && last_pix)           state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q      <= '0;
            bytes_left  <= '0;
            pixels_left <= '0;
            bpp_q       <= BPP_1;
            high_q      <= 8'h00;
            keep0_q     <= 1'b0;
            sub_idx     <= 3'd0;
            inflight    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight <= mem_enable;
            done_q   <= (accept && num_pixels == '0) || (xfer && last_pix);
            if (accept) begin
                addr_q      <= start_addr;
                bytes_left  <= bytes_calc;
                pixels_left <= num_pixels;
                bpp_q       <= bpp_log2;
                high_q      <= high_bits;
                keep0_q     <= keep_0;
                sub_idx     <= 3'd0;
            end else begin
                if (mem_enable) begin
                    addr_q     <= addr_q + 1'b1;
                    bytes_left <= bytes_left - 1'b1;
                end
                if (xfer) begin
                    pixels_left <= pixels_left - 1'b1;
                    sub_idx     <= pop ? 3'd0 : sub_idx + 3'd1;
                end
            end
        end
    end

    byte_queue2 u_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (mem_data),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count)
    );

    assign mem_addr = addr_q;
    assign done     = done_q;
    assign pix_data = extract_pixel(bpp_q, q_head, 3'(sub_idx << bpp_q), high_q, keep0_q);

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Bench for pixel_fetch_sequencer: directed scenarios plus randomized runs
// checked against a byte-array pixel model.
module tb_pixel_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, keep_0, pix_ready, mem_enable, busy, done;
    logic        pix_valid, pix_last;
    logic [10:0] start_addr, mem_addr;
    logic [9:0]  num_pixels;
    logic [1:0]  bpp_log2;
    logic [7:0]  high_bits, mem_data, pix_data;

    always #5 clk = ~clk;

    pixel_fetch_sequencer #(.ADDR_SIZE(11), .COUNT_WIDTH(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .num_pixels(num_pixels), .bpp_log2(bpp_log2), .high_bits(high_bits),
        .keep_0(keep_0), .mem_addr(mem_addr), .mem_enable(mem_enable),
        .mem_data(mem_data), .busy(busy), .done(done), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
    );

    logic [7:0] tb_mem [0:2047];

    // memory answers one cycle after enable; garbage otherwise
    always @(posedge clk) mem_data <= mem_enable ? tb_mem[mem_addr] : 8'($urandom);

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [10:0] rd_addr [$];
    int          rd_cyc [$];
    logic [7:0]  got_pix [$];
    logic        got_last [$];
    int          got_cyc [$];
    int          done_cyc [$];
    int          busy_cyc [$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_enable)            begin rd_addr.push_back(mem_addr); rd_cyc.push_back(cyc); end
            if (pix_valid && pix_ready) begin
                got_pix.push_back(pix_data); got_last.push_back(pix_last); got_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (busy) busy_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        rd_addr.delete(); rd_cyc.delete(); got_pix.delete(); got_last.delete();
        got_cyc.delete(); done_cyc.delete(); busy_cyc.delete();
    endtask

    function automatic logic [7:0] model_pix(int base, int k, int bpp, logic [7:0] hi, bit k0);
        int bits = 1 << bpp;
        int ppb  = 8 / bits;
        int b    = int'(tb_mem[(base + k / ppb) % 2048]);
        int v    = (b >> ((k % ppb) * bits)) & ((1 << bits) - 1);
        if (k0 && v == 0) return 8'h00;
        if (bits == 8)    return 8'(v);
        return 8'((int'(hi) & (255 << bits) & 255) | v);
    endfunction

    // Issues one start, then drives pix_ready at pct% until done appears.
    task automatic run(input int a, input int n, input int bpp, input logic [7:0] hi,
                       input bit k0, input int pct, output bit to, output int s);
        clear_logs();
        start = 1'b1; start_addr = 11'(a); num_pixels = 10'(n); bpp_log2 = 2'(bpp);
        high_bits = hi; keep_0 = k0;
        pix_ready = ($urandom_range(99) < pct);
        s = cyc;
        tick();
        start = 1'b0; start_addr = 11'($urandom); num_pixels = 10'($urandom);
        bpp_log2 = 2'($urandom); high_bits = 8'($urandom); keep_0 = 1'($urandom);
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (done_cyc.size() > 0) begin to = 1'b0; break; end
            pix_ready = ($urandom_range(99) < pct);
            tick();
        end
        pix_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start_addr = '0; num_pixels = '0; bpp_log2 = '0;
        high_bits = '0; keep_0 = 1'b0; pix_ready = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if ({busy, done, pix_valid, mem_enable} !== 4'b0000 || mem_addr !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy/done/valid/en=%b addr=%h, want 0000 addr=000",
                     {busy, done, pix_valid, mem_enable}, mem_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_8bpp();
        bit to; int s;
        logic [7:0] exp_p [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) tb_mem[16 + k] = exp_p[k];
        run(16, 4, 3, 8'h5A, 1'b0, 100, to, s);
        vectors++;
        if (to || got_pix.size() != 4 || rd_addr.size() != 4) begin
            miscompares++;
            $display("FAIL 8bpp_counts: timeout=%0d pixels=%0d reads=%0d, want 0 4 4", to, got_pix.size(), rd_addr.size());
        end
        for (int k = 0; k < 4 && k < got_pix.size() && k < rd_addr.size(); k++) begin
            vectors++;
            if (got_pix[k] !== exp_p[k] || got_last[k] !== (k == 3) || got_cyc[k] != s + 3 + k
                || rd_addr[k] !== 11'(16 + k) || rd_cyc[k] != s + 1 + k) begin
                miscompares++;
                $display("FAIL 8bpp_pix%0d: pix=%h last=%b cyc=%0d rd=%h@%0d, want %h %b %0d %h@%0d", k,
                         got_pix[k], got_last[k], got_cyc[k] - s, rd_addr[k], rd_cyc[k] - s,
                         exp_p[k], k == 3, 3 + k, 16 + k, 1 + k);
            end
        end
        vectors++;
        if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != s + 7)) begin
            miscompares++;
            $display("FAIL 8bpp_done: pulses=%0d first_rel=%0d, want 1 at 7", done_cyc.size(),
                     done_cyc.size() > 0 ? done_cyc[0] - s : -1);
        end
    endtask

    task automatic test_2bpp();
        bit to; int s;
        logic [7:0] exp_p [4] = '{8'h00, 8'hA1, 8'hA2, 8'hA3};
        tb_mem[40] = 8'hE4;
        run(40, 4, 1, 8'hA0, 1'b1, 100, to, s);
        vectors++;
        if (to || got_pix.size() != 4 || rd_addr.size() != 1) begin
            miscompares++;
            $display("FAIL 2bpp_counts: timeout=%0d pixels=%0d reads=%0d, want 0 4 1", to, got_pix.size(), rd_addr.size());
        end
        for (int k = 0; k < got_pix.size() && k < 4; k++) begin
            vectors++;
            if (got_pix[k] !== exp_p[k] || got_last[k] !== (k == 3)) begin
                miscompares++;
                $display("FAIL 2bpp_pix%0d: got %h/%b want %h/%b", k, got_pix[k], got_last[k], exp_p[k], k == 3);
            end
        end
    endtask

    task automatic test_1bpp();
        bit to; int s;
        tb_mem[60] = 8'hFF; tb_mem[61] = 8'h01; tb_mem[62] = 8'h77;
        run(60, 10, 0, 8'h00, 1'b0, 100, to, s);
        vectors++;
        if (to || got_pix.size() != 10 || rd_addr.size() != 2) begin
            miscompares++;
            $display("FAIL 1bpp_counts: timeout=%0d pixels=%0d reads=%0d, want 0 10 2", to, got_pix.size(), rd_addr.size());
        end
        for (int k = 0; k < got_pix.size() && k < 10; k++) begin
            vectors++;
            if (got_pix[k] !== ((k == 9) ? 8'h00 : 8'h01) || got_last[k] !== (k == 9)) begin
                miscompares++;
                $display("FAIL 1bpp_pix%0d: got %h/%b want %h/%b", k, got_pix[k], got_last[k], (k == 9) ? 8'h00 : 8'h01, k == 9);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       pv, pr, pl, cv, cl;
        logic [7:0] pd, cd;
        int         occ;
        bit         fin = 1'b0;
        tb_mem[512] = 8'h21; tb_mem[513] = 8'h43; tb_mem[514] = 8'h65;
        clear_logs();
        start = 1'b1; start_addr = 11'd512; num_pixels = 10'd6; bpp_log2 = 2'd2;
        high_bits = 8'h50; keep_0 = 1'b0; pix_ready = 1'b1;
        tick();
        start = 1'b0;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 8'h00;
        for (int c = 0; c < 200; c++) begin
            if (done_cyc.size() > 0) begin fin = 1'b1; break; end
            cv = pix_valid; cd = pix_data; cl = pix_last;
            if (pv && !pr) begin
                vectors++;
                if (!cv || cd !== pd || cl !== pl) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, want 1 %h %b", cv, cd, cl, pd, pl);
                end
            end
            occ = int'(dut.q_count) + int'(dut.inflight);
            if (occ > 2) begin
                vectors++; miscompares++;
                $display("FAIL queue_bound: occupancy=%0d, want <=2", occ);
            end
            pix_ready = (c % 2 == 0);
            pv = cv; pd = cd; pl = cl; pr = pix_ready;
            tick();
        end
        pix_ready = 1'b1;
        tick();
        vectors++;
        if (!fin || got_pix.size() != 6 || rd_addr.size() != 3) begin
            miscompares++;
            $display("FAIL bp_counts: finished=%0d pixels=%0d reads=%0d, want 1 6 3", fin, got_pix.size(), rd_addr.size());
        end
        for (int k = 0; k < got_pix.size() && k < 6; k++) begin
            vectors++;
            if (got_pix[k] !== 8'(8'h51 + k) || got_last[k] !== (k == 5)) begin
                miscompares++;
                $display("FAIL bp_pix%0d: got %h/%b want %h/%b", k, got_pix[k], got_last[k], 8'(8'h51 + k), k == 5);
            end
        end
    endtask

    task automatic test_start_busy_and_empty();
        int s;
        tb_mem[768] = 8'hA1; tb_mem[769] = 8'hA2; tb_mem[770] = 8'hA3;
        clear_logs();
        start = 1'b1; start_addr = 11'd768; num_pixels = 10'd3; bpp_log2 = 2'd3;
        high_bits = 8'h00; keep_0 = 1'b0; pix_ready = 1'b1;
        tick();
        start_addr = 11'd896; num_pixels = 10'd5;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && done_cyc.size() == 0; c++) tick();
        tick(); tick(); tick();
        vectors++;
        if (got_pix.size() != 3 || rd_addr.size() != 3 || done_cyc.size() != 1) begin
            miscompares++;
            $display("FAIL busy_start_counts: pixels=%0d reads=%0d dones=%0d, want 3 3 1", got_pix.size(), rd_addr.size(), done_cyc.size());
        end
        for (int k = 0; k < got_pix.size() && k < 3; k++) begin
            vectors++;
            if (got_pix[k] !== 8'(8'hA1 + k) || (k < rd_addr.size() && rd_addr[k] !== 11'(768 + k))) begin
                miscompares++;
                $display("FAIL busy_start_pix%0d: got %h want %h", k, got_pix[k], 8'(8'hA1 + k));
            end
        end
        clear_logs();
        start = 1'b1; start_addr = 11'd100; num_pixels = 10'd0; bpp_log2 = 2'd0;
        s = cyc;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        vectors++;
        if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != s + 1)
            || rd_addr.size() != 0 || busy_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL empty_run: dones=%0d first_rel=%0d reads=%0d busy_cycles=%0d, want 1 1 0 0",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - s : -1, rd_addr.size(), busy_cyc.size());
        end
    endtask

    task automatic test_reset_midrun();
        bit to; int s;
        for (int k = 0; k < 8; k++) tb_mem[256 + k] = 8'(8'hC0 + k);
        clear_logs();
        start = 1'b1; start_addr = 11'd256; num_pixels = 10'd8; bpp_log2 = 2'd3;
        high_bits = 8'h00; keep_0 = 1'b0; pix_ready = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        vectors++;
        if (rd_addr.size() != 2 || busy || pix_valid || mem_enable || done) begin
            miscompares++;
            $display("FAIL reset_midrun: reads=%0d busy=%b valid=%b en=%b done=%b, want 2 0 0 0 0",
                     rd_addr.size(), busy, pix_valid, mem_enable, done);
        end
        tick(); tick();
        tb_mem[1100] = 8'h3C; tb_mem[1101] = 8'h5B;
        run(1100, 4, 2, 8'h90, 1'b0, 100, to, s);
        vectors++;
        if (to || got_pix.size() != 4 || (got_pix.size() > 0 && got_pix[0] !== 8'h9C)) begin
            miscompares++;
            $display("FAIL post_reset_run: timeout=%0d pixels=%0d first=%h, want 0 4 9c", to, got_pix.size(),
                     got_pix.size() > 0 ? got_pix[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        bit to; int s, a, n, bpp, pct, ppb;
        logic [7:0] hi; bit k0;
        for (int r = 0; r < 30; r++) begin
            bpp = $urandom_range(3);
            n   = $urandom_range(1, 40);
            a   = (r % 5 == 0) ? 2045 : $urandom_range(2047);
            hi  = 8'($urandom); k0 = 1'($urandom);
            pct = (r % 3 == 0) ? 100 : $urandom_range(30, 90);
            ppb = 8 >> bpp;
            for (int j = 0; j < 40; j++) tb_mem[(a + j) % 2048] = 8'($urandom);
            run(a, n, bpp, hi, k0, pct, to, s);
            vectors++;
            if (to || got_pix.size() != n || rd_addr.size() != (n + ppb - 1) / ppb) begin
                miscompares++;
                $display("FAIL rand%0d_counts: timeout=%0d pixels=%0d reads=%0d, want 0 %0d %0d",
                         r, to, got_pix.size(), rd_addr.size(), n, (n + ppb - 1) / ppb);
            end
            for (int j = 0; j < rd_addr.size(); j++) begin
                vectors++;
                if (rd_addr[j] !== 11'((a + j) % 2048)) begin
                    miscompares++;
                    $display("FAIL rand%0d_rd%0d: addr %h want %h", r, j, rd_addr[j], 11'((a + j) % 2048));
                end
            end
            for (int k = 0; k < got_pix.size() && k < n; k++) begin
                vectors++;
                if (got_pix[k] !== model_pix(a, k, bpp, hi, k0) || got_last[k] !== (k == n - 1)
                    || (pct == 100 && k > 0 && got_cyc[k] != got_cyc[k-1] + 1)) begin
                    miscompares++;
                    $display("FAIL rand%0d_pix%0d: got %h/%b gap=%0d want %h/%b (bpp=%0d)", r, k, got_pix[k],
                             got_last[k], k > 0 ? got_cyc[k] - got_cyc[k-1] : 0,
                             model_pix(a, k, bpp, hi, k0), k == n - 1, bpp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8bpp();
        test_2bpp();
        test_1bpp();
        test_backpressure();
        test_start_busy_and_empty();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_fetch_sequencer.md
Name: pixel_fetch_sequencer

Overview:
- Streams a run of packed pixels out of pixel memory, through one read-port master interface, as one 8-bit pixel per handshake.
- Sequences byte reads, buffers up to 2 fetched bytes and unpacks 1/2/4/8 bpp pixels, LSB-first, with high-bit merge and keep-0 transparency.
- Sits between a line/layer controller (issues start commands) and the pixel compositor (consumes the stream).

Parameters:
ADDR_SIZE, 11, pixel memory byte address width
COUNT_WIDTH, 10, width of pixel count

Ports:
clk  input  1  clock
reset_n  input  1  synchronous reset, active low
start  input  1  command pulse; accepted only when busy=0
start_addr  input  ADDR_SIZE  byte address of first pixel byte
num_pixels  input  COUNT_WIDTH  pixels to emit (0 = empty run)
bpp_log2  input  2  bits per pixel = 1<<bpp_log2
high_bits  input  8  upper bits merged above narrow pixel values
keep_0  input  1  raw pixel value 0 emits 8'h00 (transparent)
mem  ReadChannel.Master  -  addr/enable out, data in; data valid exactly 1 cycle after enable
busy  output  1  run in progress
done  output  1  1-cycle pulse after last pixel handshake
pix_valid  output  1  pixel available
pix_ready  input  1  consumer accepts pixel
pix_data  output  8  unpacked pixel
pix_last  output  1  qualifies final pixel of run

Behaviour:
- Reset (reset_n=0 at posedge): busy=0, done=0, pix_valid=0, mem.enable=0, mem.addr=0, byte queue emptied, in-flight read discarded. Applies mid-run; a read returning after reset is ignored.
- Command latch: start && !busy -> register addr, bpp_log2, high_bits, keep_0, pixels_left=num_pixels, bytes_left=ceil(num_pixels / (8>>bpp_log2)); busy=1 next cycle. start while busy ignored. Config inputs sampled only at start.
- num_pixels=0: busy stays 0, no reads, done pulses the cycle after start.
- States: IDLE -> RUN (on accepted start, count>0) -> IDLE (on last pixel handshake; done=1 for the following cycle, busy=0 same cycle as done).
- Read issue (combinational enable, registered addr counter): mem.enable=1 when RUN && bytes_left>0 && (queue_count + inflight - pop) < 2, where pop = head byte's last pixel handshaked this cycle. On issue: addr++, bytes_left--. addr wraps modulo 2^ADDR_SIZE.
- Return: inflight flag registered; when set, mem.data pushed into 2-entry byte queue that cycle.
- Unpack: pixels per byte ppb=8>>bpp_log2; sub-index i counts 0..ppb-1 on head byte; bit offset = i<<bpp_log2; pix_data = extract_pixel(bpp_log2, head, bit offset, high_bits, keep_0) semantics: narrow value v in low bits, high_bits above, whole result 0 if keep_0 && v==0. 8bpp ignores high_bits.
- Handshake: pix_valid = RUN && queue nonempty. Pixel transfers when pix_valid && pix_ready. pix_data/pix_last stable while valid && !ready. On transfer: pixels_left--, i++; when i==ppb-1 or pixels_left==1, pop head, i=0. Unused trailing pixels in final byte are discarded.
- pix_last = pix_valid && pixels_left==1.
- Throughput: with pix_ready held 1, one pixel/cycle at every bpp, including 8bpp (read issued in cycle t feeds pixel in t+2 at earliest; steady state no bubbles).
- Queue never overflows: credit rule above guarantees occupancy+inflight <= 2.

Decomposition:
- Shared package: bpp_log2 encodings (BPP_1..BPP_8), ppb lookup function, the pixel-extract function (moved into the package, not duplicated).
- One sub-module: byte_queue2 (2-entry FIFO, push/pop/count, synchronous active-low reset).

Test Plan:
- 8bpp, start_addr=0x10, num_pixels=4, mem bytes 11 22 33 44, ready=1 -> reads at 0x10..0x13 on consecutive cycles, pixels 11,22,33,44 on consecutive cycles, pix_last on 44, done pulse next cycle.
- 2bpp, byte 0xE4, num_pixels=4, high_bits=0xA0, keep_0=1 -> pixels 00 (v=0 transparent), A1, A2, A3; exactly 1 read.
- 1bpp, num_pixels=10, bytes 0xFF 0x01 -> 10 pixels, 2 reads; last two pixels from byte 2 = bits0,1 = 1,0; no third read.
- Backpressure: 4bpp, 6 pixels, pix_ready toggling 1/0 -> pix_data/pix_last hold while stalled; queue never exceeds 2; exactly 3 reads total.
- start while busy, and num_pixels=0 start -> second start ignored; empty run: no mem.enable, done pulse 1 cycle after start.
- reset_n low 1 cycle mid-run with read in flight -> next cycle busy=0, pix_valid=0; returning data dropped; new run after reset emits correct first pixel.
